// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP engine: image geometry, FSM states,
// neighbour-to-window mapping and the 3x3 fetch address helper.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CRD_W  = $clog2(IMG_W);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WRITE, DONE} state_t;
  typedef logic [DATA_W-1:0] pix_t;

  // Window slot index is col*3+row (col 0 = x-1, row 0 = y-1); slot 4 is the centre.
  localparam logic [3:0] CENTRE_IDX = 4'd4;

  function automatic logic [3:0] nb_idx(input int b);
    case (b)
      0:       return 4'd0;
      1:       return 4'd3;
      2:       return 4'd6;
      3:       return 4'd1;
      4:       return 4'd7;
      5:       return 4'd2;
      6:       return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [CRD_W-1:0] y,
                                                   input logic [CRD_W-1:0] x,
                                                   input logic [3:0] f);
    logic [CRD_W-1:0] r, c;
    case (f)
      4'd0, 4'd3, 4'd6: r = '0;
      4'd1, 4'd4, 4'd7: r = CRD_W'(1);
      default:          r = CRD_W'(2);
    endcase
    case (f)
      4'd0, 4'd1, 4'd2: c = '0;
      4'd3, 4'd4, 4'd5: c = CRD_W'(1);
      default:          c = CRD_W'(2);
    endcase
    return {y + r - CRD_W'(1), x + c - CRD_W'(1)};
  endfunction

endpackage

// File: rtl/lbp_code.sv
// Combinational 8-neighbour LBP code from a 3x3 window; zero latency, no flow control.
module lbp_code
  import lbp_pkg::*;
(
  input  pix_t [8:0] win,
  output logic [7:0] code
);

  always_comb begin
    code = '0;
    for (int b = 0; b < 8; b++) begin
      code[b] = (win[nb_idx(b)] >= win[CENTRE_IDX]);
    end
  end

endmodule

// File: rtl/lbp_engine.sv
// Raster-scans the interior of a 128x128 image, 9 reads per row start then 3 per pixel,
// one LBP write per interior pixel; everything stalls while gray_ready is low.
module lbp_engine
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic              finish
);

  localparam logic [CRD_W-1:0] LAST = CRD_W'(IMG_W - 2);

  state_t           state;
  logic [CRD_W-1:0] x, y;
  logic [3:0]       f;
  pix_t [8:0]       win;
  logic             req_q;
  logic [7:0]       code;

  // Gating with gray_ready keeps the strobe low in the very cycle the memory goes away.
  assign gray_req = req_q & gray_ready;

  lbp_code u_code (
    .win  (win),
    .code (code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x         <= CRD_W'(1);
      y         <= CRD_W'(1);
      f         <= '0;
      win       <= '0;
      req_q     <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      lbp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gray_ready) begin
            state     <= LOAD;
            req_q     <= 1'b1;
            f         <= 4'd0;
            gray_addr <= fetch_addr(y, x, 4'd0);
          end
        end
        LOAD, SHIFT: begin
          if (gray_ready) begin
            win[f] <= gray_data;
            if (f == 4'd8) begin
              req_q <= 1'b0;
              state <= WRITE;
            end else begin
              f         <= f + 4'd1;
              gray_addr <= fetch_addr(y, x, f + 4'd1);
            end
          end
        end
        WRITE: begin
          if (gray_ready) begin
            lbp_valid <= 1'b1;
            lbp_addr  <= {y, x};
            lbp_data  <= code;
            if (x < LAST) begin
              // Slide left; only the new right-hand column is fetched.
              x          <= x + CRD_W'(1);
              win[2:0]   <= win[5:3];
              win[5:3]   <= win[8:6];
              f          <= 4'd6;
              gray_addr  <= fetch_addr(y, x + CRD_W'(1), 4'd6);
              req_q      <= 1'b1;
              state      <= SHIFT;
            end else if (y < LAST) begin
              x         <= CRD_W'(1);
              y         <= y + CRD_W'(1);
              f         <= 4'd0;
              gray_addr <= fetch_addr(y + CRD_W'(1), CRD_W'(1), 4'd0);
              req_q     <= 1'b1;
              state     <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine: image model drives gray memory, a negedge monitor writes the
// LBP memory and checks each write against a scoreboard queue filled from a software model.
module tb_lbp_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;

  always #5 clk = ~clk;

  logic [7:0] img     [16384];
  logic [7:0] lbp_mem [16384];

  assign gray_data = gray_req ? img[gray_addr] : 8'bz;

  lbp_engine dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   wr_count = 0;
  int   finish_rises = 0;
  int   req_viol = 0;
  logic finish_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bits in raster order over the 3x3 neighbourhood, skipping the centre.
  function automatic logic [7:0] model(input int y, input int x);
    logic [7:0] m;
    int b;
    m = '0;
    b = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dy == 0 && dx == 0)) begin
          m[b] = (img[(y + dy) * 128 + x + dx] >= img[y * 128 + x]);
          b++;
        end
      end
    end
    return m;
  endfunction

  task automatic push_expected();
    for (int y = 1; y <= 126; y++)
      for (int x = 1; x <= 126; x++)
        exp_q.push_back({14'(y * 128 + x), model(y, x)});
  endtask

  // Monitor / scoreboard consumer: LBP memory writes on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      finish_rises = 0;
      finish_d     = 1'b0;
    end else begin
      if (gray_req && !gray_ready) req_viol++;
      if (finish && !finish_d) finish_rises++;
      finish_d = finish;
      if (lbp_valid) begin
        wr_count++;
        lbp_mem[lbp_addr] = lbp_data;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra_write: got addr %0h data %0h expected no write", lbp_addr, lbp_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("sb_write", 64'({lbp_addr, lbp_data}), 64'({e.addr, e.data}));
        end
      end
    end
  end

  function automatic logic [63:0] outs();
    return 64'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish});
  endfunction

  initial begin
    int cyc;
    int idle_req;
    int post_bad;
    logic [7:0] e;

    reset      = 1'b1;
    gray_ready = 1'b1;
    for (int a = 0; a < 16384; a++) begin
      lbp_mem[a] = 8'h00;
      img[a]     = 8'($urandom_range(0, 255));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);

    // Phase A: random image, aborted by reset after ~2000 writes.
    push_expected();
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 20000 && wr_count < 2000; i++) @(posedge clk);
    check("phaseA_progress", 64'(wr_count >= 2000), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_outputs", outs(), 64'd0);
    @(negedge clk);
    check("midreset_outputs_hold", outs(), 64'd0);

    // Phase B image: flat 10, a dip, a peak and a random patch with many ties.
    exp_q.delete();
    for (int a = 0; a < 16384; a++) img[a] = 8'd10;
    img[5 * 128 + 5]   = 8'd5;
    img[20 * 128 + 20] = 8'd200;
    for (int y = 40; y <= 60; y++)
      for (int x = 30; x <= 90; x++)
        img[y * 128 + x] = (y <= 50) ? 8'($urandom_range(8, 12)) : 8'($urandom_range(0, 255));
    push_expected();
    gray_ready = 1'b0;
    wr_count   = 0;
    req_viol   = 0;
    @(posedge clk); #2;
    reset = 1'b0;

    idle_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (gray_req || lbp_valid) idle_req++;
    end
    check("ready_low_no_req", 64'(idle_req), 64'd0);

    cyc = 0;
    while (!finish && cyc < 70000) begin
      @(posedge clk); #2;
      gray_ready = ((cyc % 2500) < 2495);
      cyc++;
    end
    check("finish_within_budget", 64'(finish), 64'd1);
    gray_ready = 1'b1;
    repeat (3) @(posedge clk);

    check("write_count", 64'(wr_count), 64'd15876);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("finish_rises_once", 64'(finish_rises), 64'd1);
    check("no_req_while_not_ready", 64'(req_viol), 64'd0);

    post_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!finish || lbp_valid || gray_req) post_bad++;
    end
    check("done_stays_quiet", 64'(post_bad), 64'd0);

    for (int a = 0; a < 16384; a++) begin
      int y, x;
      y = a / 128;
      x = a % 128;
      e = (y >= 1 && y <= 126 && x >= 1 && x <= 126) ? model(y, x) : 8'h00;
      check($sformatf("mem[%0d]", a), 64'(lbp_mem[a]), 64'(e));
    end

    check("dip_5_5",   64'(lbp_mem[5 * 128 + 5]),     64'h FF);
    check("dip_4_4",   64'(lbp_mem[4 * 128 + 4]),     64'h 7F);
    check("dip_4_5",   64'(lbp_mem[4 * 128 + 5]),     64'h BF);
    check("dip_5_4",   64'(lbp_mem[5 * 128 + 4]),     64'h EF);
    check("dip_6_6",   64'(lbp_mem[6 * 128 + 6]),     64'h FE);
    check("peak_20_20", 64'(lbp_mem[20 * 128 + 20]),  64'h 00);
    check("peak_19_19", 64'(lbp_mem[19 * 128 + 19]),  64'h FF);
    check("peak_20_21", 64'(lbp_mem[20 * 128 + 21]),  64'h FF);
    check("flat_100_100", 64'(lbp_mem[100 * 128 + 100]), 64'h FF);
    check("corner_1_126", 64'(lbp_mem[1 * 128 + 126]),  64'h FF);
    check("border_0_0",  64'(lbp_mem[0]),             64'h 00);
    check("border_127_127", 64'(lbp_mem[16383]),      64'h 00);
    check("border_64_0", 64'(lbp_mem[64 * 128]),      64'h 00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
